// File: rtl/ctrl_pkg.sv
// Shared types for the multicycle controller: state encoding, opcode values
// and the coarse opcode classifier used by the decode state.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_RST, S_IF, S_DEC, S_LDI, S_MVR, S_RT, S_RT_WB,
    S_F2, S_ADI, S_LD, S_ST, S_JMP, S_HALT
  } ctrl_state_t;

  typedef enum logic [2:0] {
    C_LDI, C_MVR, C_RT, C_IMM2, C_NOP, C_HLT, C_ILL
  } op_class_t;

  localparam logic [3:0] OP_LDI0 = 4'b0000;
  localparam logic [3:0] OP_LDI1 = 4'b0001;
  localparam logic [3:0] OP_MVR  = 4'b0010;
  localparam logic [3:0] OP_ADR  = 4'b0011;
  localparam logic [3:0] OP_ANR  = 4'b0100;
  localparam logic [3:0] OP_ORR  = 4'b0101;
  localparam logic [3:0] OP_ADI  = 4'b0110;
  localparam logic [3:0] OP_LDM  = 4'b1000;
  localparam logic [3:0] OP_STM  = 4'b1001;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_JC   = 4'b1101;
  localparam logic [3:0] OP_NOP  = 4'b1110;
  localparam logic [3:0] OP_HLT  = 4'b1111;

  // Two-byte instructions all share the second-fetch state, hence one class.
  function automatic op_class_t decode_class(input logic [3:0] op);
    case (op)
      OP_LDI0, OP_LDI1:                     return C_LDI;
      OP_MVR:                               return C_MVR;
      OP_ADR, OP_ANR, OP_ORR:               return C_RT;
      OP_ADI, OP_LDM, OP_STM, OP_JMP, OP_JC: return C_IMM2;
      OP_NOP:                               return C_NOP;
      OP_HLT:                               return C_HLT;
      default:                              return C_ILL;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_p_if.sv
// Control/status bundle between the multicycle controller and its datapath.
interface multicycle_controller_p_if #(
  parameter int OP_W = 4
);
  logic [OP_W-1:0] instruction;
  logic out_jump_sel;
  logic mem_ready;

  logic ld_PC, cen_PC, ld_IR, ld_DI, ld_ALU, write_en_rf, ld_TR, ld_CZN;
  logic sel_IR_3_2, sel_DI_4_3, sel_RF_write_src_TR_12_5, sel_RF_write_src_ALU, sel_RF_write_src_reg1;
  logic sel_MEM_src_PC, sel_MEM_src_TR, sel_ALU_src_reg1, sel_ALU_src_TR;
  logic sel_CZN_src_RF, sel_CZN_src_ALU, sel_PC_src_jump;
  logic MEM_read, MEM_write;
  logic halted, illegal_op;

  modport master (
    input  instruction, out_jump_sel, mem_ready,
    output ld_PC, cen_PC, ld_IR, ld_DI, ld_ALU, write_en_rf, ld_TR, ld_CZN,
           sel_IR_3_2, sel_DI_4_3, sel_RF_write_src_TR_12_5, sel_RF_write_src_ALU,
           sel_RF_write_src_reg1, sel_MEM_src_PC, sel_MEM_src_TR, sel_ALU_src_reg1,
           sel_ALU_src_TR, sel_CZN_src_RF, sel_CZN_src_ALU, sel_PC_src_jump,
           MEM_read, MEM_write, halted, illegal_op
  );

  modport slave (
    output instruction, out_jump_sel, mem_ready,
    input  ld_PC, cen_PC, ld_IR, ld_DI, ld_ALU, write_en_rf, ld_TR, ld_CZN,
           sel_IR_3_2, sel_DI_4_3, sel_RF_write_src_TR_12_5, sel_RF_write_src_ALU,
           sel_RF_write_src_reg1, sel_MEM_src_PC, sel_MEM_src_TR, sel_ALU_src_reg1,
           sel_ALU_src_TR, sel_CZN_src_RF, sel_CZN_src_ALU, sel_PC_src_jump,
           MEM_read, MEM_write, halted, illegal_op
  );
endinterface

// File: rtl/multicycle_controller_p.sv
// Multicycle control FSM for the 8-bit accumulator/register-file datapath:
// fetch/decode, ALU, immediate, load/store, jumps and halt with a memory ready handshake.
//
// state   | meaning
// S_RST   | in or just out of reset, all strobes low
// S_IF    | instruction fetch, waits for memory ready
// S_DEC   | opcode decode, flags illegal opcodes
// S_LDI   | load immediate into DI
// S_MVR   | register move
// S_RT    | R-type ALU evaluate
// S_RT_WB | ALU result writeback
// S_F2    | second-byte fetch into TR
// S_ADI   | immediate ALU evaluate
// S_LD    | memory load into register file
// S_ST    | memory store
// S_JMP   | load PC with jump target
// S_HALT  | stopped until reset
module multicycle_controller_p
  import ctrl_pkg::*;
#(
  parameter int OP_W           = 4,
  parameter bit MEM_HANDSHAKE  = 1'b1,
  parameter bit RTYPE_SPLIT_WB = 1'b1
) (
  input logic clk,
  input logic rst,
  multicycle_controller_p_if.master bus
);

  ctrl_state_t state, state_nxt;
  logic [3:0] op;
  logic       rdy;

  assign op  = bus.instruction[OP_W-1 -: 4];
  assign rdy = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  if (OP_W > 4) begin : g_ir_lsbs
    logic unused_ir_lsbs;
    assign unused_ir_lsbs = ^bus.instruction[OP_W-5:0];
  end

  assign bus.cen_PC     = 1'b0;
  assign bus.sel_DI_4_3 = 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_RST;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt                    = state;
    bus.ld_PC                    = 1'b0;
    bus.ld_IR                    = 1'b0;
    bus.ld_DI                    = 1'b0;
    bus.ld_ALU                   = 1'b0;
    bus.write_en_rf              = 1'b0;
    bus.ld_TR                    = 1'b0;
    bus.ld_CZN                   = 1'b0;
    bus.sel_IR_3_2               = 1'b0;
    bus.sel_RF_write_src_TR_12_5 = 1'b0;
    bus.sel_RF_write_src_ALU     = 1'b0;
    bus.sel_RF_write_src_reg1    = 1'b0;
    bus.sel_MEM_src_PC           = 1'b0;
    bus.sel_MEM_src_TR           = 1'b0;
    bus.sel_ALU_src_reg1         = 1'b0;
    bus.sel_ALU_src_TR           = 1'b0;
    bus.sel_CZN_src_RF           = 1'b0;
    bus.sel_CZN_src_ALU          = 1'b0;
    bus.sel_PC_src_jump          = 1'b0;
    bus.MEM_read                 = 1'b0;
    bus.MEM_write                = 1'b0;
    bus.halted                   = 1'b0;
    bus.illegal_op               = 1'b0;

    case (state)
      S_RST: state_nxt = S_IF;

      // PC advances only on the ready cycle so wait states never skip bytes.
      S_IF: begin
        bus.sel_MEM_src_PC = 1'b1;
        bus.MEM_read       = 1'b1;
        if (rdy) begin
          bus.ld_IR = 1'b1;
          bus.ld_PC = 1'b1;
          state_nxt = S_DEC;
        end
      end

      S_DEC: begin
        case (decode_class(op))
          C_LDI:   state_nxt = S_LDI;
          C_MVR:   state_nxt = S_MVR;
          C_RT:    state_nxt = S_RT;
          C_IMM2:  state_nxt = S_F2;
          C_NOP:   state_nxt = S_IF;
          C_HLT:   state_nxt = S_HALT;
          default: begin
            bus.illegal_op = 1'b1;
            state_nxt      = S_IF;
          end
        endcase
      end

      S_LDI: begin
        bus.ld_DI = 1'b1;
        state_nxt = S_IF;
      end

      S_MVR: begin
        bus.sel_RF_write_src_reg1 = 1'b1;
        bus.write_en_rf           = 1'b1;
        bus.sel_IR_3_2            = 1'b1;
        bus.ld_CZN                = 1'b1;
        bus.sel_CZN_src_ALU       = 1'b1;
        state_nxt                 = S_IF;
      end

      S_RT: begin
        bus.sel_IR_3_2       = 1'b1;
        bus.ld_ALU           = 1'b1;
        bus.sel_ALU_src_reg1 = 1'b1;
        bus.ld_CZN           = 1'b1;
        bus.sel_CZN_src_ALU  = 1'b1;
        if (RTYPE_SPLIT_WB) begin
          state_nxt = S_RT_WB;
        end else begin
          bus.write_en_rf          = 1'b1;
          bus.sel_RF_write_src_ALU = 1'b1;
          state_nxt                = S_IF;
        end
      end

      S_RT_WB: begin
        bus.sel_RF_write_src_ALU = 1'b1;
        bus.write_en_rf          = 1'b1;
        state_nxt                = S_IF;
      end

      S_F2: begin
        bus.sel_MEM_src_PC = 1'b1;
        bus.MEM_read       = 1'b1;
        if (rdy) begin
          bus.ld_TR = 1'b1;
          bus.ld_PC = 1'b1;
          case (op)
            OP_ADI:  state_nxt = S_ADI;
            OP_LDM:  state_nxt = S_LD;
            OP_STM:  state_nxt = S_ST;
            OP_JMP:  state_nxt = S_JMP;
            OP_JC:   state_nxt = bus.out_jump_sel ? S_JMP : S_IF;
            default: state_nxt = S_IF;
          endcase
        end
      end

      S_ADI: begin
        bus.sel_ALU_src_TR  = 1'b1;
        bus.ld_ALU          = 1'b1;
        bus.ld_CZN          = 1'b1;
        bus.sel_CZN_src_ALU = 1'b1;
        state_nxt           = S_RT_WB;
      end

      S_LD: begin
        bus.sel_MEM_src_TR = 1'b1;
        bus.MEM_read       = 1'b1;
        if (rdy) begin
          bus.write_en_rf              = 1'b1;
          bus.sel_RF_write_src_TR_12_5 = 1'b1;
          bus.ld_CZN                   = 1'b1;
          bus.sel_CZN_src_RF           = 1'b1;
          state_nxt                    = S_IF;
        end
      end

      S_ST: begin
        bus.sel_MEM_src_TR = 1'b1;
        bus.MEM_write      = 1'b1;
        bus.sel_IR_3_2     = 1'b1;
        if (rdy) state_nxt = S_IF;
      end

      S_JMP: begin
        bus.sel_PC_src_jump = 1'b1;
        bus.ld_PC           = 1'b1;
        state_nxt           = S_IF;
      end

      S_HALT: bus.halted = 1'b1;

      default: state_nxt = S_RST;
    endcase
  end

endmodule
